pll_reconfig_seq: RTL
=====================

# pll_reconfig_seq

Sequencer that loads a stored PLL reconfiguration profile from PLL_RAM and writes it into the PLL reconfiguration management port. It walks the profile in PLL_RAM, issues one management write per entry, triggers the reconfiguration and waits for lock. It sits in sys_top between the video-mode logic (requester) and PLL_RAM / the PLL reconfig core.

## Interface
- ENTRIES_MAX, 32: maximum entries per profile; each entry is 2 RAM words.
- LOCK_TIMEOUT, 4096: CLOCK cycles to wait for PLL_LOCKED after the START write.
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request pulse; ignored while BUSY=1.
- PROFILE  in  2  profile select, sampled when START is accepted; base offset = PROFILE*64.
- BUSY  out  1  high from the cycle after START is accepted until DONE/ERROR.
- DONE  out  1  one-cycle pulse on successful completion.
- ERROR  out  1  sticky; set on failure, cleared by the next accepted START.
- RAM_OFFSET  out  8  PLL_RAM word address.
- RAM_RD_DATA  in  9  PLL_RAM read data; valid 1 cycle after RAM_OFFSET.
- MGMT_ADDRESS  out  6  reconfig register address.
- MGMT_WRITE  out  1  write strobe.
- MGMT_READ  out  1  read strobe (readback build only; otherwise tied 0).
- MGMT_WRITEDATA  out  32  write data.
- MGMT_READDATA  in  32  read data, valid when MGMT_READ=1 and MGMT_WAITREQUEST=0.
- MGMT_WAITREQUEST  in  1  holds the current access while high.
- PLL_LOCKED  in  1  PLL lock, treated as async: 2-flop synchronised internally.

## Operation
- RAM entry format: word 2k: [5:0] register address, [8] LAST flag, [7:6] ignored. Word 2k+1: 9-bit data, zero-extended to 32 bits.
- States:
  - IDLE
  - MODE_WR: write addr 0x00, data 0 (waitrequest mode).
  - FETCH_A: present offset base+2k.
  - FETCH_D: latch address/LAST; present base+2k+1.
  - LATCH_D: latch data.
  - ENTRY_WR
  - START_WR: write addr 0x02, data 1.
  - WAIT_LOCK
  - FINISH
- Transitions:
  - IDLE -> MODE_WR on START.
  - MODE_WR -> FETCH_A when the write is accepted.
  - FETCH_A -> FETCH_D -> LATCH_D -> ENTRY_WR.
  - ENTRY_WR, on acceptance: -> START_WR if LAST, else k+1 -> FETCH_A.
  - START_WR -> WAIT_LOCK when the write is accepted.
  - WAIT_LOCK -> FINISH on synchronised lock = 1.
  - FINISH -> IDLE with DONE = 1.
- A management access is accepted on the first edge where the strobe is 1 and MGMT_WAITREQUEST = 0.
  - Address, data and strobe are held stable until the access is accepted.
  - The strobe drops the cycle after acceptance.
- Entry counter k is 5 bits. If entry ENTRIES_MAX-1 has LAST = 0: skip START_WR, set ERROR, return to IDLE. The PLL is not started.
- WAIT_LOCK counter runs from 0. Reaching LOCK_TIMEOUT-1 sets ERROR and returns to IDLE; DONE is not pulsed.
- RAM_OFFSET arithmetic is 8-bit, base + 2k; no wrap occurs for ENTRIES_MAX ≤ 32.
- Reset values: BUSY=0, DONE=0, ERROR=0, RAM_OFFSET=0, MGMT_*=0, state=IDLE.
- Reset asserted mid-sequence: everything returns to the reset values immediately, including dropping MGMT_WRITE. No partial-completion indication is given.
- START coincident with FINISH: ignored. A new START is accepted only in IDLE.

## Timing
- START accepted at edge 0 -> BUSY=1 and MGMT_WRITE=1 (MODE_WR) after edge 0.
- With no waitrequest, each entry costs 4 cycles: FETCH_A, FETCH_D, LATCH_D, ENTRY_WR.
- Total latency START -> DONE for N entries with no waitrequest: 1 + 4N + 1 + (lock cycles + 2 sync) + 1.
- DONE and BUSY deassert on the same edge. ERROR is set on the same edge BUSY drops.

## Configuration
- PLL_RECONFIG_SEQ_READBACK_EN defined: each ENTRY_WR is followed by a READBACK state that reads the same address and compares bits [8:0].
  - Mismatch: set ERROR, abort to IDLE without START_WR.
  - Adds 1 + waitrequest cycles per entry.
- Not defined: no READBACK state; MGMT_READ is tied 0 and MGMT_READDATA is unused.

## Structure
- Package pll_reconfig_pkg holds:
  - the state enum;
  - register address constants MODE=0x00, START=0x02;
  - the entry field positions (LAST bit 8, address [5:0]).
- One sub-module: pll_lock_timer. It contains the PLL_LOCKED synchroniser and the LOCK_TIMEOUT counter, and outputs locked/timeout pulses.

## Test plan
- Profile 1, 3 entries {(0x04, 0x0A5), (0x05, 0x101), LAST (0x03, 0x1FF)}, no waitrequest, lock after 10 cycles.
  - Required: writes in the order MODE(0), 0x04/0x0A5, 0x05/0x101, 0x03/0x1FF, START(1).
  - Required: RAM_OFFSET values 64..69; one DONE pulse; ERROR = 0.
- MGMT_WAITREQUEST held high for 5 cycles on the second entry.
  - Required: address and data stable for those cycles; exactly one write accepted; order unchanged.
- PLL_LOCKED never asserts.
  - Required: ERROR = 1 and BUSY = 0 exactly LOCK_TIMEOUT cycles into WAIT_LOCK; no DONE.
- Profile with 32 entries, all LAST = 0.
  - Required: ERROR = 1 after the 32nd entry write; no START write.
- RESET_N pulsed low during entry 2 with MGMT_WRITE = 1.
  - Required: all outputs 0 immediately.
  - Required: the next START runs the full sequence from MODE_WR.
- Readback build: MGMT_READDATA returns 0x0A4 for addr 0x04.
  - Required: ERROR = 1, sequence aborts, no START write.

Source files
------------

// File: rtl/pll_reconfig_pkg.sv
// Shared types and constants for the PLL reconfiguration sequencer.
// The READBACK state exists only when PLL_RECONFIG_SEQ_READBACK_EN is defined.
package pll_reconfig_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MODE_WR   = 4'd1,
        ST_FETCH_A   = 4'd2,
        ST_FETCH_D   = 4'd3,
        ST_LATCH_D   = 4'd4,
        ST_ENTRY_WR  = 4'd5,
        ST_START_WR  = 4'd6,
        ST_WAIT_LOCK = 4'd7,
        ST_FINISH    = 4'd8
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
        , ST_READBACK = 4'd9
`endif
    } state_e;

    localparam logic [5:0] REG_MODE       = 6'h00;
    localparam logic [5:0] REG_START      = 6'h02;
    localparam int         ENTRY_LAST_BIT = 8;
    localparam int         ENTRY_ADDR_MSB = 5;

    // Word address of entry k within a profile: profile*64 + 2k + word.
    function automatic logic [7:0] entry_offset(input logic [1:0] profile,
                                                input logic [4:0] k,
                                                input logic       word);
        return {profile, 6'd0} + {2'b00, k, 1'b0} + {7'd0, word};
    endfunction

endpackage

// File: rtl/pll_lock_timer.sv
// PLL_LOCKED synchroniser plus the lock-wait timeout counter.
module pll_lock_timer #(
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic run_i,
    input  logic pll_locked_i,
    output logic locked_o,
    output logic timeout_o
);

    localparam int CW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchroniser for the asynchronous lock input.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
        end
    end

    // Counter is held at zero outside the wait so each wait starts from 0.
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign locked_o  = run_i & sync2_q;
    assign timeout_o = run_i & (cnt_q == CNT_LAST);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Walks a PLL_RAM profile into the PLL reconfig management port, starts it and waits for lock.
// Optional build macro PLL_RECONFIG_SEQ_READBACK_EN adds a read-back check after every entry write.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int ENTRIES_MAX  = 32,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [1:0]  PROFILE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [7:0]  RAM_OFFSET,
    input  logic [8:0]  RAM_RD_DATA,
    output logic [5:0]  MGMT_ADDRESS,
    output logic        MGMT_WRITE,
    output logic        MGMT_READ,
    output logic [31:0] MGMT_WRITEDATA,
    input  logic [31:0] MGMT_READDATA,
    input  logic        MGMT_WAITREQUEST,
    input  logic        PLL_LOCKED
);

    localparam logic [4:0] K_LAST = 5'(ENTRIES_MAX - 1);

    state_e     state_q, state_d;
    logic [4:0] k_q, k_d;
    logic [1:0] profile_q, profile_d;
    logic [5:0] entry_addr_q, entry_addr_d;
    logic       entry_last_q, entry_last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic [7:0] ram_offset_q, ram_offset_d;
    logic [5:0] mgmt_address_q, mgmt_address_d;
    logic       mgmt_write_q, mgmt_write_d;
    logic [8:0] wdata_q, wdata_d;
    logic       mgmt_accept_s;
    logic       entry_done_s;
    logic       entry_ok_s;
    logic       locked_s;
    logic       timeout_s;
    logic       unused_ok_s;

`ifdef PLL_RECONFIG_SEQ_READBACK_EN
    logic       mgmt_read_q, mgmt_read_d;
    assign mgmt_accept_s = (mgmt_write_q | mgmt_read_q) & ~MGMT_WAITREQUEST;
    assign MGMT_READ     = mgmt_read_q;
    assign unused_ok_s   = ^{MGMT_READDATA[31:9], RAM_RD_DATA[7:6]};
`else
    assign mgmt_accept_s = mgmt_write_q & ~MGMT_WAITREQUEST;
    assign MGMT_READ     = 1'b0;
    assign unused_ok_s   = ^{MGMT_READDATA, RAM_RD_DATA[7:6]};
`endif

    pll_lock_timer #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_lock_timer (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .run_i        (state_q == ST_WAIT_LOCK),
        .pll_locked_i (PLL_LOCKED),
        .locked_o     (locked_s),
        .timeout_o    (timeout_s)
    );

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        profile_d      = profile_q;
        entry_addr_d   = entry_addr_q;
        entry_last_d   = entry_last_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        error_d        = error_q;
        ram_offset_d   = ram_offset_q;
        mgmt_address_d = mgmt_address_q;
        mgmt_write_d   = mgmt_write_q;
        wdata_d        = wdata_q;
        entry_done_s   = 1'b0;
        entry_ok_s     = 1'b1;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
        mgmt_read_d    = mgmt_read_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d        = ST_MODE_WR;
                    busy_d         = 1'b1;
                    error_d        = 1'b0;
                    profile_d      = PROFILE;
                    k_d            = 5'd0;
                    ram_offset_d   = entry_offset(PROFILE, 5'd0, 1'b0);
                    mgmt_address_d = REG_MODE;
                    wdata_d        = 9'd0;
                    mgmt_write_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MODE_WR, ST_START_WR: begin
                if (mgmt_accept_s) begin
                    mgmt_write_d = 1'b0;
                    state_d      = (state_q == ST_MODE_WR) ? ST_FETCH_A : ST_WAIT_LOCK;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH_A: begin
                state_d      = ST_FETCH_D;
                ram_offset_d = entry_offset(profile_q, k_q, 1'b1);
            end
            ST_FETCH_D: begin
                state_d      = ST_LATCH_D;
                entry_addr_d = RAM_RD_DATA[ENTRY_ADDR_MSB:0];
                entry_last_d = RAM_RD_DATA[ENTRY_LAST_BIT];
            end
            ST_LATCH_D: begin
                state_d        = ST_ENTRY_WR;
                wdata_d        = RAM_RD_DATA;
                mgmt_address_d = entry_addr_q;
                mgmt_write_d   = 1'b1;
            end
            ST_ENTRY_WR: begin
                if (mgmt_accept_s) begin
                    mgmt_write_d = 1'b0;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
                    mgmt_read_d  = 1'b1;
                    state_d      = ST_READBACK;
`else
                    entry_done_s = 1'b1;
`endif
                end else begin
                    state_d = ST_ENTRY_WR;
                end
            end
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
            ST_READBACK: begin
                if (mgmt_accept_s) begin
                    mgmt_read_d  = 1'b0;
                    entry_done_s = 1'b1;
                    entry_ok_s   = (MGMT_READDATA[8:0] == wdata_q);
                end else begin
                    state_d = ST_READBACK;
                end
            end
`endif
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                mgmt_write_d = 1'b0;
            end
        endcase

        // An entry is finished: start the PLL, move on, or abort without starting it.
        if (entry_done_s) begin
            if (!entry_ok_s || (!entry_last_q && (k_q == K_LAST))) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                error_d = 1'b1;
            end else if (entry_last_q) begin
                state_d        = ST_START_WR;
                mgmt_address_d = REG_START;
                wdata_d        = 9'd1;
                mgmt_write_d   = 1'b1;
            end else begin
                state_d      = ST_FETCH_A;
                k_d          = k_q + 5'd1;
                ram_offset_d = entry_offset(profile_q, k_q + 5'd1, 1'b0);
            end
        end else begin
            entry_ok_s = 1'b1;
        end
    end

    // State and registered-output update.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            k_q            <= 5'd0;
            profile_q      <= 2'd0;
            entry_addr_q   <= 6'd0;
            entry_last_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            ram_offset_q   <= 8'd0;
            mgmt_address_q <= 6'd0;
            mgmt_write_q   <= 1'b0;
            wdata_q        <= 9'd0;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
            mgmt_read_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            profile_q      <= profile_d;
            entry_addr_q   <= entry_addr_d;
            entry_last_q   <= entry_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            ram_offset_q   <= ram_offset_d;
            mgmt_address_q <= mgmt_address_d;
            mgmt_write_q   <= mgmt_write_d;
            wdata_q        <= wdata_d;
`ifdef PLL_RECONFIG_SEQ_READBACK_EN
            mgmt_read_q    <= mgmt_read_d;
`endif
        end
    end

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign ERROR          = error_q;
    assign RAM_OFFSET     = ram_offset_q;
    assign MGMT_ADDRESS   = mgmt_address_q;
    assign MGMT_WRITE     = mgmt_write_q;
    assign MGMT_WRITEDATA = {23'd0, wdata_q};

endmodule
